// File: rtl/fsm_stream_scheduler_if.sv
// Request/response bundle between two word requesters, a result
// consumer and the shared serial-FSM scheduler.
interface fsm_stream_scheduler_if #(
   parameter int DATA_W = 8
);
   logic              req0_valid;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_id;
   logic              rsp_ready;

   modport master (
      output req0_valid, req0_data,
      output req1_valid, req1_data,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req0_valid, req0_data,
      input  req1_valid, req1_data,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/fsm_stream_scheduler.sv
// Shares one serial Mealy FSM between two word requesters: streams the
// granted word LSB-first into the FSM and gathers its Z bits as a result.
module fsm_stream_scheduler #(
   parameter int DATA_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   fsm_stream_scheduler_if.slave bus,
   output logic                 fsm_rst,
   output logic                 fsm_x,
   input  logic                 fsm_z,
   output logic                 busy
);
   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

   state_t            state;
   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] res;
   logic [CW-1:0]     cnt;
   logic              last;
   logic              id_q;
   logic              valid_q;
   logic              pick1;
   logic              take0;
   logic              take1;

   // Round-robin: on contention the requester not served last wins
   assign pick1 = bus.req1_valid && (!bus.req0_valid || !last);
   assign take0 = (state == IDLE) && !reset && bus.req0_valid && !pick1;
   assign take1 = (state == IDLE) && !reset && pick1;

   assign bus.req0_ready = take0;
   assign bus.req1_ready = take1;
   assign bus.rsp_valid  = valid_q;
   assign bus.rsp_data   = res;
   assign bus.rsp_id     = id_q;
   assign busy           = (state != IDLE);
   assign fsm_x          = sh[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sh      <= '0;
         res     <= '0;
         cnt     <= '0;
         last    <= 1'b1;
         id_q    <= 1'b0;
         valid_q <= 1'b0;
         fsm_rst <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (take0 || take1) begin
                  sh      <= take1 ? bus.req1_data : bus.req0_data;
                  id_q    <= take1;
                  last    <= take1;
                  cnt     <= '0;
                  res     <= '0;
                  fsm_rst <= 1'b0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               // Shifting sh out fully leaves fsm_x at 0 after the job
               res <= {fsm_z, res[DATA_W-1:1]};
               sh  <= sh >> 1;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  valid_q <= 1'b1;
                  fsm_rst <= 1'b1;
                  state   <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fsm_stream_scheduler.sv
// Directed bench for fsm_stream_scheduler with a behavioural model of
// the shared Mealy detector hanging off fsm_x/fsm_z/fsm_rst.
module tb_fsm_stream_scheduler;
   logic clk;
   logic reset;
   logic fsm_rst;
   logic fsm_x;
   logic fsm_z;
   logic busy;

   int tests = 0;
   int fails = 0;

   fsm_stream_scheduler_if #(.DATA_W(8)) bus ();

   fsm_stream_scheduler #(.DATA_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .fsm_rst (fsm_rst),
      .fsm_x   (fsm_x),
      .fsm_z   (fsm_z),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Detector: Z=1 on x=1 in AC; AC-1->B-0->C-1->D-0->E-1->AC
   localparam logic [2:0] AC = 3'd0, SB = 3'd1, SC = 3'd2,
                          SD = 3'd3, SE = 3'd4;
   logic [2:0] st;
   always_comb fsm_z = (st == AC) ? fsm_x : 1'b0;
   always_ff @(posedge clk or posedge fsm_rst) begin
      if (fsm_rst) st <= AC;
      else begin
         case (st)
            AC: st <= fsm_x ? SB : AC;
            SB: st <= fsm_x ? SB : SC;
            SC: st <= fsm_x ? SD : SC;
            SD: st <= fsm_x ? SD : SE;
            SE: st <= fsm_x ? AC : SE;
            default: st <= AC;
         endcase
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Called just after a negedge; returns at the sample where rsp_valid rose
   task automatic run_job(input logic id, input logic [7:0] d,
                          output logic [7:0] rd, output logic rid,
                          output int lat, output logic [7:0] xs,
                          output int nlow);
      int n;
      if (id) begin
         bus.req1_valid = 1'b1;
         bus.req1_data  = d;
      end else begin
         bus.req0_valid = 1'b1;
         bus.req0_data  = d;
      end
      #1;
      n = 0;
      while (!(id ? bus.req1_ready : bus.req0_ready) && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("handshake_wait", 32'(n < 50), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
      lat  = 1;
      xs   = '0;
      nlow = 0;
      while (!bus.rsp_valid && lat < 40) begin
         if (!fsm_rst) begin
            if (nlow < 8) xs[nlow] = fsm_x;
            nlow++;
         end
         @(negedge clk);
         lat++;
      end
      rd  = bus.rsp_data;
      rid = bus.rsp_id;
   endtask

   typedef struct {
      logic       id;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [7:0] rd;
      logic       rid;
      int         lat;
      logic [7:0] xs;
      int         nlow;
      int         nrsp;
      int         cyc;
      int         prev;
      logic       both;
      logic [7:0] exp_d[4];
      logic       exp_i[4];

      vecs[0] = '{1'b0, 8'hAA, 8'h82};
      vecs[1] = '{1'b0, 8'h00, 8'h00};
      vecs[2] = '{1'b1, 8'hFF, 8'h01};
      vecs[3] = '{1'b0, 8'h01, 8'h01};
      vecs[4] = '{1'b1, 8'h02, 8'h02};
      vecs[5] = '{1'b1, 8'hAA, 8'h82};
      vecs[6] = '{1'b0, 8'hFF, 8'h01};
      exp_d = '{8'h82, 8'h01, 8'h82, 8'h01};
      exp_i = '{1'b0, 1'b1, 1'b0, 1'b1};

      reset          = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req0_data  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_data  = '0;
      bus.rsp_ready  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_state",
            {busy, fsm_rst, fsm_x, bus.rsp_valid, bus.rsp_data,
             bus.rsp_id, bus.req0_ready, bus.req1_ready},
            {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      reset = 1'b0;

      foreach (vecs[i]) begin
         run_job(vecs[i].id, vecs[i].data, rd, rid, lat, xs, nlow);
         check($sformatf("v%0d_rsp_data", i), rd, vecs[i].exp);
         check($sformatf("v%0d_rsp_id", i), rid, vecs[i].id);
         check($sformatf("v%0d_latency", i), lat, 9);
         check($sformatf("v%0d_x_seq", i), xs, vecs[i].data);
         check($sformatf("v%0d_rst_low", i), nlow, 8);
      end

      // Contention: both valid continuously, grants must alternate
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset          = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'hAA;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'hFF;
      nrsp = 0;
      cyc  = 0;
      prev = 0;
      both = 1'b0;
      while (nrsp < 4 && cyc < 100) begin
         #1;
         if (bus.req0_ready && bus.req1_ready) both = 1'b1;
         if (bus.rsp_valid) begin
            check($sformatf("rr%0d_id", nrsp), bus.rsp_id, exp_i[nrsp]);
            check($sformatf("rr%0d_data", nrsp), bus.rsp_data, exp_d[nrsp]);
            if (nrsp > 0)
               check($sformatf("rr%0d_period", nrsp), cyc - prev, 10);
            prev = cyc;
            nrsp++;
         end
         if (nrsp < 4) begin
            @(negedge clk);
            cyc++;
         end
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check("rr_responses", nrsp, 4);
      check("rr_single_ready", both, 1'b0);
      @(negedge clk);

      // Backpressure in RESP with a competing request waiting
      bus.rsp_ready = 1'b0;
      run_job(1'b0, 8'hAA, rd, rid, lat, xs, nlow);
      check("bp_first", {bus.rsp_valid, rd}, {1'b1, 8'h82});
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h55;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d", i),
               {bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req0_ready,
                bus.req1_ready, fsm_rst, fsm_x, busy},
               {1'b1, 8'h82, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release", {busy, bus.rsp_valid, bus.req1_ready},
            {1'b0, 1'b0, 1'b1});
      bus.req1_valid = 1'b0;
      @(negedge clk);

      // Reset on the 4th SHIFT cycle of a req1 job
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h02;
      #1;
      cyc = 0;
      while (!bus.req1_ready && cyc < 50) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("rst_handshake_wait", 32'(cyc < 50), 32'd1);
      @(posedge clk);
      repeat (4) @(negedge clk);
      check("rst_pre", {busy, fsm_rst, bus.rsp_id, bus.rsp_data},
            {1'b1, 1'b0, 1'b1, 8'h40});
      reset = 1'b1;
      #1;
      check("rst_mid",
            {busy, fsm_rst, fsm_x, bus.rsp_valid, bus.rsp_data,
             bus.rsp_id, bus.req0_ready, bus.req1_ready},
            {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("rst_hold%0d", i),
               {bus.rsp_valid, bus.req1_ready, fsm_rst}, {1'b0, 1'b0, 1'b1});
      end
      reset = 1'b0;
      run_job(1'b1, 8'h02, rd, rid, lat, xs, nlow);
      check("rst_resume_data", rd, 8'h02);
      check("rst_resume_id", rid, 1'b1);
      check("rst_resume_lat", lat, 9);
      @(negedge clk);

      // Idle with no requests
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("idle%0d", i),
               {busy, fsm_rst, bus.req0_ready, bus.req1_ready, bus.rsp_valid},
               5'b01000);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
